// File: rtl/soc_bus_pkg.sv
// Shared definitions for the two-master SoC bus: arbiter FSM states,
// lock-length default and the peripheral address map on A[8:4].
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_e;

  // Longest run of locked re-grants one master may take while the other waits.
  localparam int MAX_LOCK_DEFAULT = 8;

  // Address map, decoded on A[8:4].
  localparam logic [4:0] DMEM_SEL_LO = 5'h00;
  localparam logic [4:0] DMEM_SEL_HI = 5'h0F;
  localparam logic [4:0] FACT_SEL    = 5'h10;
  localparam logic [4:0] GPIO_SEL    = 5'h12;

  // Select field of a byte address as seen by the address decoder.
  function automatic logic [4:0] addr_sel(input logic [31:0] addr);
    return addr[8:4];
  endfunction

endpackage

// File: rtl/bus_rr_select.sv
// Two-way round-robin picker: when both masters request, the one that was
// not granted last wins; a lone requester always wins.
module bus_rr_select (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic pick
);

  assign valid = req0 | req1;
  assign pick  = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (m0 = CPU, m1 = DMA). Each transfer is an ACCESS
// cycle (address/data on the shared bus, gnt high) followed by a RESP cycle
// (ack pulse, read data returned). A master holding lock is re-granted up to
// MAX_LOCK times in a row while the other master is waiting.
module bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_gnt,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_gnt,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wd,
  input  logic [31:0] bus_rd
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  bus_state_e       state;
  logic             owner;     // 0 = m0, 1 = m1
  logic             last;      // master granted most recently
  logic [CNT_W-1:0] lock_cnt;

  logic rr_valid;
  logic rr_pick;

  bus_rr_select u_rr (
    .req0  (m0_req),
    .req1  (m1_req),
    .last  (last),
    .valid (rr_valid),
    .pick  (rr_pick)
  );

  logic own_req, own_lock, other_req, locked_regrant;

  assign own_req   = owner ? m1_req  : m0_req;
  assign own_lock  = owner ? m1_lock : m0_lock;
  assign other_req = owner ? m0_req  : m1_req;

  // A locked re-grant only counts when it actually keeps the other master
  // waiting; with an idle peer the round-robin re-grants the owner anyway.
  assign locked_regrant = own_req && own_lock && other_req && (lock_cnt < LOCK_MAX);

  // Arbitration FSM: state, owner, round-robin history and lock run length.
  // NOTE: every register here, including the FSM state, is reset
  // asynchronously and updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          lock_cnt <= '0;
          if (rr_valid) begin
            state <= ACCESS;
            owner <= rr_pick;
            last  <= rr_pick;
          end
        end
        ACCESS: begin
          state <= RESP;
        end
        RESP: begin
          if (locked_regrant) begin
            state    <= ACCESS;
            lock_cnt <= lock_cnt + 1'b1;
          end else if (rr_valid) begin
            state <= ACCESS;
            owner <= rr_pick;
            last  <= rr_pick;
            if (rr_pick != owner) lock_cnt <= '0;
          end else begin
            state    <= IDLE;
            lock_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state, so reset clears them immediately.
  logic in_access, in_resp;

  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);

  assign m0_gnt = in_access && !owner;
  assign m1_gnt = in_access &&  owner;
  assign m0_ack = in_resp   && !owner;
  assign m1_ack = in_resp   &&  owner;
  assign m0_rd  = m0_ack ? bus_rd : '0;
  assign m1_rd  = m1_ack ? bus_rd : '0;

  assign bus_we   = in_access && (owner ? m1_we : m0_we);
  assign bus_addr = in_access ? (owner ? m1_addr : m0_addr) : '0;
  assign bus_wd   = in_access ? (owner ? m1_wd   : m0_wd)   : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a vector table for single transfers and
// back-to-back arbitration, plus hand-written lock and reset sequences.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_lock, m0_we;
  logic [31:0] m0_addr, m0_wd, m0_rd;
  logic        m0_gnt, m0_ack;
  logic        m1_req, m1_lock, m1_we;
  logic [31:0] m1_addr, m1_wd, m1_rd;
  logic        m1_gnt, m1_ack;
  logic        bus_we;
  logic [31:0] bus_addr, bus_wd, bus_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_LOCK(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_req   (m0_req),
    .m0_lock  (m0_lock),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wd    (m0_wd),
    .m0_gnt   (m0_gnt),
    .m0_ack   (m0_ack),
    .m0_rd    (m0_rd),
    .m1_req   (m1_req),
    .m1_lock  (m1_lock),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wd    (m1_wd),
    .m1_gnt   (m1_gnt),
    .m1_ack   (m1_ack),
    .m1_rd    (m1_rd),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wd   (bus_wd),
    .bus_rd   (bus_rd)
  );

  typedef struct {
    logic        rst_before;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wd;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wd;
    logic [31:0] bus_rd;
    logic        e_gnt0, e_gnt1, e_ack0, e_ack1;
    logic [31:0] e_rd0, e_rd1;
    logic        e_we;
    logic [31:0] e_addr, e_wd;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  function automatic vec_t mk(
    input logic rst,
    input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
    input logic [31:0] brd,
    input logic g0, input logic g1, input logic k0, input logic k1,
    input logic [31:0] rd0, input logic [31:0] rd1,
    input logic we, input logic [31:0] addr, input logic [31:0] wd);
    vec_t v;
    v.rst_before = rst;
    v.m0_req = r0; v.m0_we = w0; v.m0_addr = a0; v.m0_wd = d0;
    v.m1_req = r1; v.m1_we = w1; v.m1_addr = a1; v.m1_wd = d1;
    v.bus_rd = brd;
    v.e_gnt0 = g0; v.e_gnt1 = g1; v.e_ack0 = k0; v.e_ack1 = k1;
    v.e_rd0 = rd0; v.e_rd1 = rd1;
    v.e_we = we; v.e_addr = addr; v.e_wd = wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wd = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wd = '0;
    bus_rd = '0;
  endtask

  // Leaves the bench one time unit after a rising edge with the DUT in IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("rst gnt/ack", {28'd0, m0_gnt, m1_gnt, m0_ack, m1_ack}, 32'd0);
    check("rst bus_we", {31'd0, bus_we}, 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst rd", m0_rd | m1_rd, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    m0_req = v.m0_req; m0_we = v.m0_we; m0_addr = v.m0_addr; m0_wd = v.m0_wd;
    m1_req = v.m1_req; m1_we = v.m1_we; m1_addr = v.m1_addr; m1_wd = v.m1_wd;
    m0_lock = 0; m1_lock = 0;
    bus_rd = v.bus_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acks, first_m1, both, last_ack, bad;

    // Single CPU read.
    vecs[0]  = mk(1, 1,0,32'h40,0,      0,0,0,0,        32'hDEADBEEF, 0,0,0,0, 0,0,            0,0,0);
    vecs[1]  = mk(0, 1,0,32'h40,0,      0,0,0,0,        32'hDEADBEEF, 1,0,0,0, 0,0,            0,32'h40,0);
    vecs[2]  = mk(0, 0,0,0,0,           0,0,0,0,        32'hDEADBEEF, 0,0,1,0, 32'hDEADBEEF,0, 0,0,0);
    vecs[3]  = mk(0, 0,0,0,0,           0,0,0,0,        32'hDEADBEEF, 0,0,0,0, 0,0,            0,0,0);
    // Simultaneous requests after reset: m0 write first, m1 read with no IDLE gap.
    vecs[4]  = mk(1, 1,1,32'h120,5,     1,0,32'h100,0,  32'h12345678, 0,0,0,0, 0,0,            0,0,0);
    vecs[5]  = mk(0, 1,1,32'h120,5,     1,0,32'h100,0,  32'h12345678, 1,0,0,0, 0,0,            1,32'h120,5);
    vecs[6]  = mk(0, 0,0,0,0,           1,0,32'h100,0,  32'h12345678, 0,0,1,0, 32'h12345678,0, 0,0,0);
    vecs[7]  = mk(0, 0,0,0,0,           1,0,32'h100,0,  32'h12345678, 0,1,0,0, 0,0,            0,32'h100,0);
    vecs[8]  = mk(0, 0,0,0,0,           0,0,0,0,        32'hCAFE0001, 0,0,0,1, 0,32'hCAFE0001, 0,0,0);
    vecs[9]  = mk(0, 0,0,0,0,           0,0,0,0,        32'hCAFE0001, 0,0,0,0, 0,0,            0,0,0);
    // m1 drops req during ACCESS: transfer still completes.
    vecs[10] = mk(0, 0,0,0,0,           1,1,32'h108,32'h77, 32'h0,    0,0,0,0, 0,0,            0,0,0);
    vecs[11] = mk(0, 0,0,0,0,           0,1,32'h108,32'h77, 32'h0,    0,1,0,0, 0,0,            1,32'h108,32'h77);
    vecs[12] = mk(0, 0,0,0,0,           0,0,0,0,        32'h55,       0,0,0,1, 0,32'h55,       0,0,0);
    vecs[13] = mk(0, 0,0,0,0,           0,0,0,0,        32'h55,       0,0,0,0, 0,0,            0,0,0);

    clear_inputs();
    rst_n = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].rst_before) do_reset();
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d m0_gnt", i), {31'd0, m0_gnt}, {31'd0, vecs[i].e_gnt0});
      check($sformatf("v%0d m1_gnt", i), {31'd0, m1_gnt}, {31'd0, vecs[i].e_gnt1});
      check($sformatf("v%0d m0_ack", i), {31'd0, m0_ack}, {31'd0, vecs[i].e_ack0});
      check($sformatf("v%0d m1_ack", i), {31'd0, m1_ack}, {31'd0, vecs[i].e_ack1});
      check($sformatf("v%0d m0_rd", i), m0_rd, vecs[i].e_rd0);
      check($sformatf("v%0d m1_rd", i), m1_rd, vecs[i].e_rd1);
      check($sformatf("v%0d bus_we", i), {31'd0, bus_we}, {31'd0, vecs[i].e_we});
      check($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].e_addr);
      check($sformatf("v%0d bus_wd", i), bus_wd, vecs[i].e_wd);
      @(posedge clk);
      #1;
    end

    // Lock limit: m0 locked, m1 waiting -> 9 m0 transfers, then m1 at cycle 19.
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h44;
    m1_req = 1; m1_addr = 32'h104;
    bus_rd = 32'h0BAD_F00D;
    acks = 0; first_m1 = -1; both = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (m0_ack) acks++;
      if (m0_gnt && m1_gnt) both++;
      if (m1_gnt) begin
        first_m1 = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("lock m0 transfers", acks, 32'd9);
    check("lock m1 first grant cycle", first_m1, 32'd19);
    check("lock dual grant", both, 32'd0);
    @(posedge clk);
    #1;
    m0_req = 0; m0_lock = 0;
    @(negedge clk);
    check("lock m1_ack", {31'd0, m1_ack}, 32'd1);
    check("lock m1_rd", m1_rd, 32'h0BAD_F00D);
    m1_req = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lock back to idle", {30'd0, m0_gnt, m1_gnt}, 32'd0);

    // Lock with idle peer: 20 consecutive m0 transfers, never a switch.
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h48;
    acks = 0; last_ack = -1; bad = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (m1_gnt || m1_ack) bad++;
      if (m0_ack) begin
        acks++;
        last_ack = cyc;
        if (acks == 20) begin
          m0_req = 0; m0_lock = 0;
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    check("idle-peer m0 acks", acks, 32'd20);
    check("idle-peer last ack cycle", last_ack, 32'd40);
    check("idle-peer m1 activity", bad, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle-peer back to idle", {31'd0, m0_gnt}, 32'd0);

    // Reset during an m1 write ACCESS: bus_we drops at once, no ack, m0 first after.
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h104; m1_wd = 32'hAA;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstmid m1_gnt before", {31'd0, m1_gnt}, 32'd1);
    check("rstmid bus_we before", {31'd0, bus_we}, 32'd1);
    check("rstmid bus_wd before", bus_wd, 32'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid bus_we async", {31'd0, bus_we}, 32'd0);
    check("rstmid m1_gnt async", {31'd0, m1_gnt}, 32'd0);
    check("rstmid bus_addr async", bus_addr, 32'd0);
    m1_req = 0; m1_we = 0;
    bad = 0;
    @(posedge clk);
    #1;
    if (m1_ack) bad++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m0_req = 1; m0_addr = 32'h4C;
    m1_req = 1; m1_we = 1;
    bus_rd = 32'h600D_0000;
    @(negedge clk);
    if (m1_ack) bad++;
    @(posedge clk);
    #1;
    @(negedge clk);
    if (m1_ack) bad++;
    check("rstmid m0 served first", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    @(posedge clk);
    #1;
    m0_req = 0;
    @(negedge clk);
    check("rstmid m0_ack", {31'd0, m0_ack}, 32'd1);
    check("rstmid m0_rd", m0_rd, 32'h600D_0000);
    check("rstmid no stale m1_ack", bad, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstmid m1 regranted", {31'd0, m1_gnt}, 32'd1);
    m1_req = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_LOCK, default 8, meaning maximum consecutive locked transfers granted to one master while the other master is requesting.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  CPU master transfer request
- m0_lock  in  1  CPU master requests back-to-back retention of the bus
- m0_we  in  1  CPU master write enable
- m0_addr  in  32  CPU master byte address
- m0_wd  in  32  CPU master write data
- m0_gnt  out  1  CPU master owns the bus this cycle
- m0_ack  out  1  CPU master transfer complete, one-cycle pulse
- m0_rd  out  32  CPU master read data, valid when m0_ack=1
- m1_req, m1_lock, m1_we, m1_addr, m1_wd, m1_gnt, m1_ack, m1_rd  same as m0_*, for the DMA master
- bus_we  out  1  shared write enable to address_decoder WE
- bus_addr  out  32  shared address to address_decoder A and peripherals
- bus_wd  out  32  shared write data
- bus_rd  in  32  shared read data from RdSel mux; valid one cycle after address phase

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS, RESP; a 1-bit register owner SHALL record the master in ACCESS/RESP.
REQ-005 In IDLE with any mx_req=1, the next state SHALL be ACCESS, with owner chosen by round-robin.
REQ-006 Round-robin SHALL favour the master not granted last; register last resets to 1, so m0 wins the first simultaneous request after reset.
REQ-007 In ACCESS, the block SHALL drive bus_addr/bus_we/bus_wd from the owner's inputs and assert that master's gnt; next state SHALL be RESP.
REQ-008 Outside ACCESS, the block SHALL drive bus_we=0, bus_addr=0 and bus_wd=0; no write SHALL reach the bus without a grant.
REQ-009 In RESP, the block SHALL pulse the owner's ack for exactly one cycle and drive that master's rd = bus_rd; the other master's ack SHALL be 0.
REQ-010 The non-owner's rd SHALL be 0 at all times.
REQ-011 Latency SHALL be 2 cycles from the req sample edge to ack; throughput SHALL be one transfer per 2 cycles.
REQ-012 From RESP, if any req=1, the next state SHALL be ACCESS directly, bypassing IDLE; otherwise it SHALL be IDLE.
REQ-013 Arbitration in RESP SHALL use the round-robin choice unless the owner has req=1 and lock=1 and lock_cnt<MAX_LOCK, in which case the owner SHALL be re-granted.
REQ-014 lock_cnt SHALL increment on each locked re-grant, clear on an owner change or IDLE, and saturate at MAX_LOCK.
- When the other master is idle, lock_cnt SHALL NOT force a switch.
- A re-grant to the same owner because no other master is requesting SHALL keep lock_cnt unchanged.
REQ-015 Masters SHALL hold req, we, addr and wd stable from req assertion until ack.
- If req drops during ACCESS, the transfer SHALL still complete and ack SHALL still pulse.
REQ-016 lock without req SHALL be ignored.

Reset
REQ-017 While rst_n=0, the state SHALL be IDLE, owner=0, last=1 and lock_cnt=0.
REQ-018 While rst_n=0, all outputs SHALL be 0, including bus_we, which SHALL clear asynchronously.
REQ-019 A reset asserted mid-transfer SHALL abort the transfer with no ack; the master SHALL re-request afterwards.

Structure
REQ-020 Package soc_bus_pkg SHALL hold:
- the state enum IDLE/ACCESS/RESP;
- the MAX_LOCK default;
- address-map constants: data memory A[8:4] 0x00-0x0F, factorial accelerator 0x10, GPIO 0x12.
REQ-021 A combinational sub-module bus_rr_select (inputs req0, req1, last; outputs valid, pick) SHALL implement REQ-006.

Verification
REQ-022 The bench SHALL cover:
- Single CPU read: m0_req with addr 0x0000_0040, bus_rd=0xDEAD_BEEF -> m0_gnt in cycle 1, m0_ack with m0_rd=0xDEAD_BEEF in cycle 2, bus_we=0 throughout.
- Simultaneous requests after reset: m0 write 0x120 data 0x5, m1 read 0x100 -> m0 granted first with bus_we=1 only in its ACCESS cycle, then m1 is granted with no IDLE gap.
- Lock limit: m0 locked and m1 requesting with MAX_LOCK=8 -> exactly 9 m0 transfers (1 + 8 re-grants), then m1 is granted.
- Lock with idle peer: m0 locked for 20 transfers, m1 idle -> 20 consecutive m0 acks, no switch.
- Reset mid-transfer: assert rst_n=0 during an m1 ACCESS write -> bus_we falls immediately, no m1_ack; after release, an m0 request is served first.
